uart_tx_arbiter: RTL



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_arbiter_if.sv | 23 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx arbiter slice.
// One-hot FSM encoding mirrors the transmitter's state style.
package uart_pkg;

   localparam int FR_W_DEF = 12;
   localparam int IDX_W    = 3;

   typedef enum logic [4:0] {
      S_IDLE      = 5'b00001,
      S_LAUNCH    = 5'b00010,
      S_WAIT_BUSY = 5'b00100,
      S_WAIT_DONE = 5'b01000,
      S_ACK       = 5'b10000
   } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bus of the uart_tx arbiter.
// Master is the producer group, slave is the arbiter.
interface uart_tx_arbiter_if #(
   parameter int NREQ = 4
);

   logic [NREQ-1:0]   REQ;
   logic [NREQ*8-1:0] REQ_DATA;
   logic [NREQ-1:0]   ACK;

   modport master (
      output REQ,
      output REQ_DATA,
      input  ACK
   );

   modport slave (
      input  REQ,
      input  REQ_DATA,
      output ACK
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit from ptr upward.
// Shared with the future RX-side dispatcher.
module rr_pick
   import uart_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic             vld,
   output logic [IDX_W-1:0] idx
);

   int j;

   // Scan from farthest to nearest so the nearest hit wins.
   always_comb begin
      vld = |req;
      idx = '0;
      j   = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % NREQ;
         if (req[j]) idx = IDX_W'(j);
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among NREQ producers.
// Holds byte and bit period stable for the whole frame.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int FR_W = FR_W_DEF,
   parameter int TMO  = 4
) (
   input  logic             PCLK,
   input  logic             RESET,
   uart_tx_arbiter_if.slave rq,
   input  logic [FR_W-1:0]  WORK_FR_CFG,
   output logic [IDX_W-1:0] GNT_IDX,
   output logic             BUSY,
   output logic             ERR,
   output logic [7:0]       TX_DATA_O,
   output logic [FR_W-1:0]  TX_WORK_FR_O,
   output logic             TX_START_O,
   input  logic             TX_READY_I
);

   localparam int CW = $clog2(TMO + 1);

   state_t           state_q, state_d;
   logic [NREQ-1:0]  ack_q, ack_d;
   logic [IDX_W-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [7:0]       data_q, data_d;
   logic [FR_W-1:0]  fr_q, fr_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic             start_q, start_d;
   logic             pick_vld;
   logic [IDX_W-1:0] pick_idx;
   logic [IDX_W-1:0] nxt;

   rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req (rq.REQ),
      .ptr (ptr_q),
      .vld (pick_vld),
      .idx (pick_idx)
   );

   assign nxt = (int'(gnt_q) == NREQ - 1) ? '0 : gnt_q + 1'b1;

   always_ff @(posedge PCLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         ack_q   <= '0;
         gnt_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         data_q  <= 8'h00;
         fr_q    <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         fr_q    <= fr_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         start_q <= start_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ack_d   = '0;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      fr_d    = fr_q;
      busy_d  = busy_q;
      err_d   = 1'b0;
      start_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (pick_vld && TX_READY_I) begin
               data_d  = rq.REQ_DATA[8*int'(pick_idx) +: 8];
               fr_d    = WORK_FR_CFG;
               gnt_d   = pick_idx;
               busy_d  = 1'b1;
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            start_d = 1'b1;
            cnt_d   = '0;
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (!TX_READY_I) begin
               state_d = S_WAIT_DONE;
            end else if (cnt_q == CW'(TMO - 1)) begin
               // Skip past the granted slot so a dead launch cannot starve others.
               err_d   = 1'b1;
               busy_d  = 1'b0;
               ptr_d   = nxt;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (TX_READY_I) begin
               for (int i = 0; i < NREQ; i++)
                  ack_d[i] = (gnt_q == IDX_W'(i));
               busy_d  = 1'b0;
               ptr_d   = nxt;
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign rq.ACK       = ack_q;
   assign GNT_IDX      = gnt_q;
   assign BUSY         = busy_q;
   assign ERR          = err_q;
   assign TX_DATA_O    = data_q;
   assign TX_WORK_FR_O = fr_q;
   assign TX_START_O   = start_q;

endmodule
